// File: rtl/rs_age_sel.sv
// rs_age_sel: out-of-order reservation station for one functional unit.
// Holds DEPTH ops and tracks operand readiness through NUM_WK wakeup ports.
// Each cycle it issues the oldest ready op, using a DEPTH x DEPTH age matrix.
// Optional feature macro: RS_SELECTIVE_FLUSH_EN. When it is defined, a flush
// kills only the entries at or younger than flush_rob, measured relative to
// rob_head. When it is undefined, a flush clears every entry.
module rs_age_sel #(
    parameter int DEPTH     = 8,
    parameter int NUM_WK    = 3,
    parameter int PREG_W    = 7,
    parameter int ROB_W     = 4,
    parameter int PAYLOAD_W = 39
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     valid_in,
    output logic                     ready_in,
    input  logic [PREG_W-1:0]        in_prd,
    input  logic [PREG_W-1:0]        in_pr1,
    input  logic [PREG_W-1:0]        in_pr2,
    input  logic                     in_rdy1,
    input  logic                     in_rdy2,
    input  logic [ROB_W-1:0]         in_rob,
    input  logic [PAYLOAD_W-1:0]     in_payload,
    input  logic                     fu_rdy,
    output logic                     valid_out,
    output logic [PREG_W-1:0]        out_prd,
    output logic [PREG_W-1:0]        out_pr1,
    output logic [PREG_W-1:0]        out_pr2,
    output logic [ROB_W-1:0]         out_rob,
    output logic [PAYLOAD_W-1:0]     out_payload,
    output logic                     nr_valid,
    output logic [PREG_W-1:0]        nr_reg,
    input  logic [NUM_WK-1:0]        wk_valid,
    input  logic [NUM_WK*PREG_W-1:0] wk_tag,
    input  logic                     flush,
    input  logic [ROB_W-1:0]         flush_rob,
    input  logic [ROB_W-1:0]         rob_head
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Per-entry storage.
    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     rdy1_q;
    logic [DEPTH-1:0]     rdy2_q;
    logic [PREG_W-1:0]    prd_q     [DEPTH];
    logic [PREG_W-1:0]    pr1_q     [DEPTH];
    logic [PREG_W-1:0]    pr2_q     [DEPTH];
    logic [ROB_W-1:0]     rob_q     [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    // older_q[i][j] = 1 means entry i was dispatched before entry j.
    // Bits that belong to invalid entries are stale, and select ignores them.
    logic [DEPTH-1:0]     older_q   [DEPTH];

    logic [DEPTH-1:0] wk_m1;
    logic [DEPTH-1:0] wk_m2;
    logic             in_m1;
    logic             in_m2;
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] kill;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] sel;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic             issue;
    logic             accept;

    // Match the wakeup tags against the dispatching op and the resident entries.
    always_comb begin
        in_m1 = 1'b0;
        in_m2 = 1'b0;
        wk_m1 = '0;
        wk_m2 = '0;
        for (int k = 0; k < NUM_WK; k++) begin
            if (wk_valid[k]) begin
                if (wk_tag[k*PREG_W +: PREG_W] == in_pr1) in_m1 = 1'b1;
                if (wk_tag[k*PREG_W +: PREG_W] == in_pr2) in_m2 = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    if (wk_tag[k*PREG_W +: PREG_W] == pr1_q[i]) wk_m1[i] = 1'b1;
                    if (wk_tag[k*PREG_W +: PREG_W] == pr2_q[i]) wk_m2[i] = 1'b1;
                end
            end
        end
    end

`ifdef RS_SELECTIVE_FLUSH_EN
    logic [ROB_W-1:0] flush_dist;
    logic [ROB_W-1:0] entry_dist;

    // Kill the entries that are at or younger than flush_rob, relative to the ROB head.
    always_comb begin
        kill       = '0;
        entry_dist = '0;
        flush_dist = flush_rob - rob_head;
        for (int i = 0; i < DEPTH; i++) begin
            entry_dist = rob_q[i] - rob_head;
            if (flush && (entry_dist >= flush_dist)) kill[i] = 1'b1;
        end
    end
`else
    logic unused_flush_info;
    assign unused_flush_info = ^{flush_rob, rob_head};

    // A full flush kills every entry.
    always_comb begin
        kill = {DEPTH{flush}};
    end
`endif

    // Eligibility includes same-cycle wakeups. Killed entries never compete for issue.
    always_comb begin
        elig = valid_q & (rdy1_q | wk_m1) & (rdy2_q | wk_m2);
        cand = elig & ~kill;
    end

    // Select the oldest candidate. Candidate i wins if no candidate j is older than i.
    always_comb begin
        sel     = cand;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (cand[j] && older_q[j][i]) sel[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) sel_idx = IDX_W'(i);
        end
    end

    // Find the lowest-index free entry for dispatch.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign ready_in = ~&valid_q;
    assign accept   = valid_in & ready_in & ~flush;
    assign issue    = fu_rdy & (|cand);

    // Entry state, age matrix and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q     <= '0;
            rdy1_q      <= '0;
            rdy2_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                prd_q[i]     <= '0;
                pr1_q[i]     <= '0;
                pr2_q[i]     <= '0;
                rob_q[i]     <= '0;
                payload_q[i] <= '0;
                older_q[i]   <= '0;
            end
            valid_out   <= 1'b0;
            out_prd     <= '0;
            out_pr1     <= '0;
            out_pr2     <= '0;
            out_rob     <= '0;
            out_payload <= '0;
            nr_valid    <= 1'b0;
            nr_reg      <= '0;
        end else begin
            rdy1_q <= rdy1_q | wk_m1;
            rdy2_q <= rdy2_q | wk_m2;

            valid_out <= issue;
            if (issue) begin
                valid_q[sel_idx] <= 1'b0;
                out_prd          <= prd_q[sel_idx];
                out_pr1          <= pr1_q[sel_idx];
                out_pr2          <= pr2_q[sel_idx];
                out_rob          <= rob_q[sel_idx];
                out_payload      <= payload_q[sel_idx];
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (kill[i]) valid_q[i] <= 1'b0;
            end

            nr_valid <= accept;
            if (accept) begin
                nr_reg              <= in_prd;
                valid_q[free_idx]   <= 1'b1;
                rdy1_q[free_idx]    <= in_rdy1 | in_m1;
                rdy2_q[free_idx]    <= in_rdy2 | in_m2;
                prd_q[free_idx]     <= in_prd;
                pr1_q[free_idx]     <= in_pr1;
                pr2_q[free_idx]     <= in_pr2;
                rob_q[free_idx]     <= in_rob;
                payload_q[free_idx] <= in_payload;
                older_q[free_idx]   <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != int'(free_idx)) older_q[j][free_idx] <= valid_q[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_age_sel.sv
// tb_rs_age_sel: directed, self-checking bench for rs_age_sel.
// The default build exercises the full flush. With RS_SELECTIVE_FLUSH_EN
// defined, the bench exercises the selective flush instead.
module tb_rs_age_sel;

    logic        clk;
    logic        reset_n;
    logic        valid_in;
    logic        ready_in;
    logic [6:0]  in_prd, in_pr1, in_pr2;
    logic        in_rdy1, in_rdy2;
    logic [3:0]  in_rob;
    logic [38:0] in_payload;
    logic        fu_rdy;
    logic        valid_out;
    logic [6:0]  out_prd, out_pr1, out_pr2;
    logic [3:0]  out_rob;
    logic [38:0] out_payload;
    logic        nr_valid;
    logic [6:0]  nr_reg;
    logic [2:0]  wk_valid;
    logic [20:0] wk_tag;
    logic        flush;
    logic [3:0]  flush_rob;
    logic [3:0]  rob_head;

    int checks = 0;
    int fails  = 0;

    rs_age_sel dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in),
        .in_prd(in_prd), .in_pr1(in_pr1), .in_pr2(in_pr2),
        .in_rdy1(in_rdy1), .in_rdy2(in_rdy2), .in_rob(in_rob), .in_payload(in_payload),
        .fu_rdy(fu_rdy), .valid_out(valid_out), .out_prd(out_prd), .out_pr1(out_pr1),
        .out_pr2(out_pr2), .out_rob(out_rob), .out_payload(out_payload),
        .nr_valid(nr_valid), .nr_reg(nr_reg), .wk_valid(wk_valid), .wk_tag(wk_tag),
        .flush(flush), .flush_rob(flush_rob), .rob_head(rob_head)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_in   = 1'b0;
        in_prd     = '0;
        in_pr1     = '0;
        in_pr2     = '0;
        in_rdy1    = 1'b0;
        in_rdy2    = 1'b0;
        in_rob     = '0;
        in_payload = '0;
        wk_valid   = '0;
        wk_tag     = '0;
        flush      = 1'b0;
        flush_rob  = '0;
        rob_head   = '0;
    endtask

    task automatic drive_dispatch(input logic [6:0] prd, input logic [6:0] pr1, input logic r1,
                                  input logic [6:0] pr2, input logic r2, input logic [3:0] rob);
        valid_in   = 1'b1;
        in_prd     = prd;
        in_pr1     = pr1;
        in_rdy1    = r1;
        in_pr2     = pr2;
        in_rdy2    = r2;
        in_rob     = rob;
        in_payload = {prd, 32'hC0DE_0000};
    endtask

    task automatic drive_wake(input logic [2:0] v, input logic [6:0] t0,
                              input logic [6:0] t1, input logic [6:0] t2);
        wk_valid = v;
        wk_tag   = {t2, t1, t0};
    endtask

    task automatic test_reset();
        clear_inputs();
        fu_rdy  = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid_out: got %b want 0", valid_out); end
        checks++; if (nr_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_nr_valid: got %b want 0", nr_valid); end
        checks++; if (out_prd !== 7'd0) begin fails++; $display("[TB] FAIL reset_out_prd: got %0d want 0", out_prd); end
        checks++; if (ready_in !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready_in: got %b want 1", ready_in); end
    endtask

    task automatic test_wakeup_issue();
        fu_rdy = 1'b1;
        drive_dispatch(7'd10, 7'd1, 1'b0, 7'd2, 1'b0, 4'd1);
        step();
        clear_inputs();
        checks++; if (nr_valid !== 1'b1) begin fails++; $display("[TB] FAIL wk_nr_valid: got %b want 1", nr_valid); end
        checks++; if (nr_reg !== 7'd10) begin fails++; $display("[TB] FAIL wk_nr_reg: got %0d want 10", nr_reg); end
        checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL wk_no_issue_dispatch: got %b want 0", valid_out); end
        step();
        checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL wk_no_issue_idle: got %b want 0", valid_out); end
        drive_wake(3'b001, 7'd1, 7'd0, 7'd0);
        step();
        clear_inputs();
        checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL wk_tag1_only: got %b want 0", valid_out); end
        step();
        checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL wk_after_tag1: got %b want 0", valid_out); end
        drive_wake(3'b001, 7'd2, 7'd0, 7'd0);
        step();
        clear_inputs();
        checks++; if (valid_out !== 1'b1) begin fails++; $display("[TB] FAIL wk_tag2_issue: got %b want 1", valid_out); end
        checks++; if (out_prd !== 7'd10) begin fails++; $display("[TB] FAIL wk_out_prd: got %0d want 10", out_prd); end
        checks++; if (out_rob !== 4'd1) begin fails++; $display("[TB] FAIL wk_out_rob: got %0d want 1", out_rob); end
        checks++; if (out_pr2 !== 7'd2) begin fails++; $display("[TB] FAIL wk_out_pr2: got %0d want 2", out_pr2); end
        checks++; if (out_payload !== {7'd10, 32'hC0DE_0000}) begin fails++; $display("[TB] FAIL wk_out_payload: got %h want %h", out_payload, {7'd10, 32'hC0DE_0000}); end
        step();
        checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL wk_pulse_one_cycle: got %b want 0", valid_out); end
        checks++; if (out_prd !== 7'd10) begin fails++; $display("[TB] FAIL wk_out_hold: got %0d want 10", out_prd); end
    endtask

    task automatic test_fill();
        logic [6:0] exp_order [7];
        exp_order = '{7'd30, 7'd31, 7'd32, 7'd34, 7'd35, 7'd36, 7'd37};
        fu_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_dispatch(7'(30 + i), 7'(40 + i), 1'b0, 7'd0, 1'b1, 4'(i));
            step();
            if (i == 6) begin
                checks++; if (ready_in !== 1'b1) begin fails++; $display("[TB] FAIL fill_ready_7: got %b want 1", ready_in); end
            end
        end
        clear_inputs();
        checks++; if (ready_in !== 1'b0) begin fails++; $display("[TB] FAIL fill_full: got %b want 0", ready_in); end
        drive_wake(3'b001, 7'd43, 7'd0, 7'd0);
        step();
        clear_inputs();
        checks++; if (valid_out !== 1'b1 || out_prd !== 7'd33) begin fails++; $display("[TB] FAIL fill_wake_one: got v=%b prd=%0d want v=1 prd=33", valid_out, out_prd); end
        checks++; if (ready_in !== 1'b1) begin fails++; $display("[TB] FAIL fill_ready_after_issue: got %b want 1", ready_in); end
        for (int n = 0; n < 7; n++) begin
            if (n == 0) drive_wake(3'b111, 7'd40, 7'd41, 7'd42);
            else if (n == 1) drive_wake(3'b111, 7'd44, 7'd45, 7'd46);
            else if (n == 2) drive_wake(3'b001, 7'd47, 7'd0, 7'd0);
            step();
            clear_inputs();
            checks++; if (valid_out !== 1'b1 || out_prd !== exp_order[n]) begin fails++; $display("[TB] FAIL fill_drain_%0d: got v=%b prd=%0d want v=1 prd=%0d", n, valid_out, out_prd, exp_order[n]); end
        end
        step();
        checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL fill_empty: got %b want 0", valid_out); end
    endtask

    task automatic test_age_order();
        fu_rdy = 1'b1;
        drive_dispatch(7'd50, 7'd51, 1'b0, 7'd0, 1'b1, 4'd5);
        step();
        drive_dispatch(7'd52, 7'd53, 1'b0, 7'd0, 1'b1, 4'd6);
        step();
        clear_inputs();
        drive_wake(3'b001, 7'd53, 7'd0, 7'd0);
        step();
        clear_inputs();
        checks++; if (valid_out !== 1'b1 || out_rob !== 4'd6) begin fails++; $display("[TB] FAIL age_b_first: got v=%b rob=%0d want v=1 rob=6", valid_out, out_rob); end
        drive_wake(3'b001, 7'd51, 7'd0, 7'd0);
        step();
        clear_inputs();
        checks++; if (valid_out !== 1'b1 || out_rob !== 4'd5) begin fails++; $display("[TB] FAIL age_a_second: got v=%b rob=%0d want v=1 rob=5", valid_out, out_rob); end
        drive_dispatch(7'd60, 7'd61, 1'b0, 7'd0, 1'b1, 4'd7);
        step();
        drive_dispatch(7'd62, 7'd63, 1'b0, 7'd0, 1'b1, 4'd8);
        step();
        clear_inputs();
        drive_wake(3'b001, 7'd61, 7'd0, 7'd0);
        step();
        clear_inputs();
        checks++; if (valid_out !== 1'b1 || out_rob !== 4'd7) begin fails++; $display("[TB] FAIL age_p_issue: got v=%b rob=%0d want v=1 rob=7", valid_out, out_rob); end
        // The youngest op R lands in entry 0, below the older op Q.
        drive_dispatch(7'd64, 7'd65, 1'b0, 7'd0, 1'b1, 4'd9);
        step();
        clear_inputs();
        fu_rdy = 1'b0;
        drive_wake(3'b011, 7'd63, 7'd65, 7'd0);
        step();
        clear_inputs();
        checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL age_fu_busy: got %b want 0", valid_out); end
        fu_rdy = 1'b1;
        step();
        checks++; if (valid_out !== 1'b1 || out_rob !== 4'd8) begin fails++; $display("[TB] FAIL age_oldest_first: got v=%b rob=%0d want v=1 rob=8", valid_out, out_rob); end
        step();
        checks++; if (valid_out !== 1'b1 || out_rob !== 4'd9) begin fails++; $display("[TB] FAIL age_younger_next: got v=%b rob=%0d want v=1 rob=9", valid_out, out_rob); end
        step();
        checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL age_empty: got %b want 0", valid_out); end
    endtask

    task automatic test_dispatch_bypass();
        fu_rdy = 1'b1;
        drive_dispatch(7'd20, 7'd21, 1'b0, 7'd22, 1'b1, 4'd3);
        drive_wake(3'b100, 7'd0, 7'd0, 7'd21);
        step();
        clear_inputs();
        checks++; if (nr_valid !== 1'b1 || nr_reg !== 7'd20) begin fails++; $display("[TB] FAIL bypass_nr: got v=%b reg=%0d want v=1 reg=20", nr_valid, nr_reg); end
        checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL bypass_not_same_cycle: got %b want 0", valid_out); end
        step();
        checks++; if (valid_out !== 1'b1 || out_prd !== 7'd20) begin fails++; $display("[TB] FAIL bypass_issue: got v=%b prd=%0d want v=1 prd=20", valid_out, out_prd); end
        checks++; if (nr_valid !== 1'b0) begin fails++; $display("[TB] FAIL bypass_nr_pulse: got %b want 0", nr_valid); end
    endtask

`ifdef RS_SELECTIVE_FLUSH_EN
    task automatic test_flush();
        fu_rdy = 1'b0;
        drive_dispatch(7'd80, 7'd81, 1'b0, 7'd0, 1'b1, 4'd15);
        step();
        drive_dispatch(7'd82, 7'd83, 1'b0, 7'd0, 1'b1, 4'd0);
        step();
        drive_dispatch(7'd84, 7'd85, 1'b0, 7'd0, 1'b1, 4'd1);
        step();
        clear_inputs();
        flush     = 1'b1;
        flush_rob = 4'd0;
        rob_head  = 4'd14;
        step();
        clear_inputs();
        checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL sflush_no_issue: got %b want 0", valid_out); end
        fu_rdy = 1'b1;
        drive_wake(3'b111, 7'd81, 7'd83, 7'd85);
        step();
        clear_inputs();
        checks++; if (valid_out !== 1'b1 || out_rob !== 4'd15 || out_prd !== 7'd80) begin fails++; $display("[TB] FAIL sflush_survivor: got v=%b rob=%0d prd=%0d want v=1 rob=15 prd=80", valid_out, out_rob, out_prd); end
        for (int n = 0; n < 3; n++) begin
            step();
            checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL sflush_killed_%0d: got %b want 0", n, valid_out); end
        end
    endtask
`else
    task automatic test_flush();
        fu_rdy = 1'b0;
        drive_dispatch(7'd70, 7'd71, 1'b1, 7'd0, 1'b1, 4'd2);
        step();
        drive_dispatch(7'd72, 7'd73, 1'b0, 7'd0, 1'b1, 4'd3);
        step();
        clear_inputs();
        fu_rdy = 1'b1;
        flush  = 1'b1;
        drive_dispatch(7'd74, 7'd75, 1'b1, 7'd0, 1'b1, 4'd4);
        step();
        clear_inputs();
        checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL flush_forced_zero: got %b want 0", valid_out); end
        checks++; if (nr_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_drop_dispatch: got %b want 0", nr_valid); end
        for (int n = 0; n < 4; n++) begin
            drive_wake(3'b111, 7'd71, 7'd73, 7'd75);
            step();
            checks++; if (valid_out !== 1'b0) begin fails++; $display("[TB] FAIL flush_no_issue_%0d: got %b want 0", n, valid_out); end
            checks++; if (ready_in !== 1'b1) begin fails++; $display("[TB] FAIL flush_ready_%0d: got %b want 1", n, ready_in); end
        end
        clear_inputs();
    endtask
`endif

    // Run the scenarios in sequence and print the summary.
    initial begin
        clear_inputs();
        reset_n = 1'b0;
        fu_rdy  = 1'b0;
        test_reset();
        test_wakeup_issue();
        test_fill();
        test_age_order();
        test_dispatch_bypass();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
